// File: rtl/iterative_mult_unit.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, signed/unsigned.
// Optional build macro MULT_EARLY_TERM_EN ends the iteration once the remaining multiplier bits are zero.
module iterative_mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 m_signed,
  input  logic [WIDTH-1:0]     src_a,
  input  logic [WIDTH-1:0]     src_b,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [WIDTH-1:0]     mult_q, mult_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic                 last_step;

  // Negating the most-negative value wraps to itself, which is the correct unsigned magnitude.
  always_comb begin
    mag_a = (m_signed && src_a[WIDTH-1]) ? ({WIDTH{1'b0}} - src_a) : src_a;
    mag_b = (m_signed && src_b[WIDTH-1]) ? ({WIDTH{1'b0}} - src_b) : src_b;
  end

  always_comb begin
`ifdef MULT_EARLY_TERM_EN
    // At least one step always runs, so minimum latency stays at two edges.
    last_step = (cnt_q == CW'(WIDTH)) || ((cnt_q != '0) && (mult_q == '0));
`else
    last_step = (cnt_q == CW'(WIDTH));
`endif
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mult_d    = mult_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;
    ready     = (state_q != RUN);
    done      = (state_q == FIN);

    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          state_d = RUN;
          acc_d   = '0;
          mcand_d = {{WIDTH{1'b0}}, mag_a};
          mult_d  = mag_b;
          cnt_d   = '0;
          neg_d   = m_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (last_step) begin
          state_d   = FIN;
          product_d = neg_q ? ({(2*WIDTH){1'b0}} - acc_q) : acc_q;
        end else begin
          if (mult_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d = mcand_q << 1;
          mult_d  = mult_q >> 1;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mult_q    <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mult_q    <= mult_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_iterative_mult_unit.sv
// Self-checking bench for iterative_mult_unit: randomized operands against an arithmetic reference.
module tb_iterative_mult_unit;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           m_signed;
  logic [W-1:0]   src_a;
  logic [W-1:0]   src_b;
  logic           ready;
  logic           done;
  logic [2*W-1:0] product;

  int             total = 0;
  int             bad = 0;
  logic [2*W-1:0] last_prod;

  iterative_mult_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .m_signed (m_signed),
    .src_a    (src_a),
    .src_b    (src_b),
    .ready    (ready),
    .done     (done),
    .product  (product)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic int ref_lat(input logic s, input logic [W-1:0] b);
`ifdef MULT_EARLY_TERM_EN
    longint mb;
    int n;
    mb = s ? longint'($signed(b)) : longint'(b);
    if (mb < 0) mb = -mb;
    n = 1;
    for (int i = 0; i < W; i++) if (mb[i]) n = i + 1;
    return n + 1;
`else
    return W + 1;
`endif
  endfunction

  // Launch one operation (start is sampled at the next edge, E0) and run to its done pulse.
  // Leaves the bench in the done cycle. poke_at > 0 re-pulses start so it is sampled at that edge.
  task automatic do_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int poke_at, input string name);
    logic [2*W-1:0] exp_p;
    int exp_l, lat;
    bit rd_bad, hold_bad;
    exp_p = ref_mul(s, a, b);
    exp_l = ref_lat(s, b);
    start = 1'b1; m_signed = s; src_a = a; src_b = b;
    tick();
    start = 1'b0; src_a = $urandom; src_b = $urandom; m_signed = 1'($urandom);
    lat = 0; rd_bad = 0; hold_bad = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (ready !== 1'b0) rd_bad = 1;
      if (product !== last_prod) hold_bad = 1;
      start = (poke_at > 0 && lat == poke_at - 1) ? 1'b1 : 1'b0;
      tick();
      lat++;
    end
    start = 1'b0;
    total++;
    if (lat !== exp_l) begin
      bad++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_l);
    end
    total++;
    if (product !== exp_p) begin
      bad++; $display("FAIL %s product: got %h expected %h", name, product, exp_p);
    end
    total++;
    if (rd_bad || hold_bad || ready !== 1'b1) begin
      bad++; $display("FAIL %s busy/hold: ready_low_err=%0d hold_err=%0d ready_at_done=%b expected 0 0 1",
                      name, rd_bad, hold_bad, ready);
    end
    last_prod = exp_p;
  endtask

  task automatic after_done(input string name);
    tick();
    total++;
    if (done !== 1'b0 || ready !== 1'b1 || product !== last_prod) begin
      bad++; $display("FAIL %s after-done: done=%b ready=%b product=%h expected 0 1 %h",
                      name, done, ready, product, last_prod);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; m_signed = 1'b0; src_a = '0; src_b = '0;
    repeat (3) tick();
    total++;
    if (ready !== 1'b1 || done !== 1'b0 || product !== '0) begin
      bad++; $display("FAIL reset_state: ready=%b done=%b product=%h expected 1 0 0", ready, done, product);
    end
    start = 1'b1; src_a = 32'd9; src_b = 32'd9;
    tick();
    reset = 1'b0; start = 1'b0;
    tick();
    total++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL start_under_reset: ready=%b done=%b expected 1 0", ready, done);
    end
    last_prod = '0;
  endtask

  task automatic test_directed();
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "umax");
    total++;
    if (product !== 64'hFFFF_FFFE_0000_0001) begin
      bad++; $display("FAIL umax_const: got %h expected fffffffe00000001", product);
    end
    after_done("umax");
    do_op(1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 0, "neg2x3");
    total++;
    if (product !== 64'hFFFF_FFFF_FFFF_FFFA) begin
      bad++; $display("FAIL neg2x3_const: got %h expected fffffffffffffffa", product);
    end
    after_done("neg2x3");
    do_op(1'b1, 32'h8000_0000, 32'h8000_0000, 0, "minxmin");
    after_done("minxmin");
    do_op(1'b1, 32'h8000_0000, 32'h0000_0001, 0, "minx1");
    after_done("minx1");
    do_op(1'b1, 32'h0000_0000, 32'hFFFF_FFF0, 0, "zero_a");
    after_done("zero_a");
    do_op(1'b0, 32'h1234_5678, 32'h0000_0000, 0, "zero_b");
    after_done("zero_b");
    do_op(1'b0, 32'h1234_5678, 32'h0000_0003, 0, "x3");
    after_done("x3");
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      do_op(1'($urandom), $urandom, (i % 4 == 0) ? W'($urandom_range(0, 255)) : $urandom, 0, "random");
      after_done("random");
    end
  endtask

  task automatic test_ignore_start();
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, "busy_start");
    after_done("busy_start");
    tick();
    total++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL busy_start_no_queue: ready=%b done=%b expected 1 0", ready, done);
    end
  endtask

  task automatic test_back_to_back();
    do_op(1'b0, 32'd7, 32'd6, 0, "b2b_first");
    total++;
    if (product !== 64'd42) begin
      bad++; $display("FAIL b2b_first_const: got %0d expected 42", product);
    end
    do_op(1'b0, 32'd5, 32'd5, 0, "b2b_second");
    total++;
    if (product !== 64'd25) begin
      bad++; $display("FAIL b2b_second_const: got %0d expected 25", product);
    end
    after_done("b2b_second");
  endtask

  task automatic test_abort();
    int dones;
    start = 1'b1; m_signed = 1'b0; src_a = 32'hDEAD_BEEF; src_b = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (ready !== 1'b1 || done !== 1'b0 || product !== '0) begin
      bad++; $display("FAIL abort_state: ready=%b done=%b product=%h expected 1 0 0", ready, done, product);
    end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++; $display("FAIL abort_no_done: got %0d done pulses expected 0", dones);
    end
    last_prod = '0;
  endtask

  initial begin
    last_prod = '0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_abort();
    do_op(1'b1, 32'hFFFF_FFF9, 32'd6, 0, "post_abort");
    after_done("post_abort");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
